// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;
  localparam int DIV_WIDTH = 8;

  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int CNT_W = cnt_w(DIV_WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
endpackage

// File: rtl/div_8bit_seq_if.sv
// Start/done handshake and result bus between the control unit and the divider.
interface div_8bit_seq_if #(parameter int WIDTH = div_pkg::DIV_WIDTH);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
  logic             overflow;

  modport master (output start, dividend, divisor,
                  input  ready, busy, done, quotient, remainder, div_by_zero, overflow);
  modport slave  (input  start, dividend, divisor,
                  output ready, busy, done, quotient, remainder, div_by_zero, overflow);
endinterface

// File: rtl/div_step.sv
// One restoring-division step: trial subtract divisor from the shifted partial remainder.
module div_step #(parameter int WIDTH = 8) (
  input  logic [WIDTH-1:0] r,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] r_next,
  output logic             q_bit
);
  // One extra guard bit so the MSB is a clean borrow for any operands
  logic [WIDTH+1:0] trial;

  assign trial  = {1'b0, r, bit_in} - {2'b00, divisor};
  assign q_bit  = ~trial[WIDTH+1];
  assign r_next = q_bit ? trial[WIDTH-1:0] : {r[WIDTH-2:0], bit_in};
endmodule

// File: rtl/div_8bit_seq.sv
// Sequential restoring divider, one quotient bit per clock.
// Define DIV_SIGNED_EN for two's complement operands (truncating division).
module div_8bit_seq
  import div_pkg::*;
#(parameter int WIDTH = DIV_WIDTH) (
  input logic          clk,
  input logic          rst,
  div_8bit_seq_if.slave bus
);
  localparam int CW = cnt_w(WIDTH);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] r_reg, q_reg, dvsr;
  logic [WIDTH-1:0] r_nxt, q_nxt, a_ld, b_ld, q_fin, r_fin;
  logic             q_bit;

  div_step #(.WIDTH(WIDTH)) u_step (
    .r(r_reg), .bit_in(q_reg[WIDTH-1]), .divisor(dvsr),
    .r_next(r_nxt), .q_bit(q_bit)
  );

  assign q_nxt = {q_reg[WIDTH-2:0], q_bit};

`ifdef DIV_SIGNED_EN
  logic neg_q, neg_r, ovf_pend;

  // Core works on magnitudes; the most negative value maps to itself, read as unsigned
  assign a_ld  = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
  assign b_ld  = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
  assign q_fin = neg_q ? -q_nxt : q_nxt;
  assign r_fin = neg_r ? -r_nxt : r_nxt;
`else
  assign a_ld         = bus.dividend;
  assign b_ld         = bus.divisor;
  assign q_fin        = q_nxt;
  assign r_fin        = r_nxt;
  assign bus.overflow = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= '0;
      r_reg           <= '0;
      q_reg           <= '0;
      dvsr            <= '0;
      bus.ready       <= 1'b1;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.quotient    <= '0;
      bus.remainder   <= '0;
      bus.div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_q           <= 1'b0;
      neg_r           <= 1'b0;
      ovf_pend        <= 1'b0;
      bus.overflow    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            if (bus.divisor == '0) begin
              // No iterations needed: results are fixed by definition
              bus.quotient    <= '1;
              bus.remainder   <= bus.dividend;
              bus.div_by_zero <= 1'b1;
              bus.done        <= 1'b1;
`ifdef DIV_SIGNED_EN
              bus.overflow    <= 1'b0;
`endif
              state           <= DONE;
            end else begin
              r_reg           <= '0;
              q_reg           <= a_ld;
              dvsr            <= b_ld;
              cnt             <= '0;
              bus.div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
              neg_q           <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
              neg_r           <= bus.dividend[WIDTH-1];
              ovf_pend        <= (bus.dividend == {1'b1, {(WIDTH-1){1'b0}}}) &&
                                 (bus.divisor == '1);
              bus.overflow    <= 1'b0;
`endif
              bus.busy        <= 1'b1;
              bus.ready       <= 1'b0;
              state           <= CALC;
            end
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          r_reg <= r_nxt;
          q_reg <= q_nxt;
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            bus.quotient  <= q_fin;
            bus.remainder <= r_fin;
`ifdef DIV_SIGNED_EN
            bus.overflow  <= ovf_pend;
`endif
            bus.done      <= 1'b1;
            bus.busy      <= 1'b0;
            bus.ready     <= 1'b1;
            state         <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_8bit_seq.sv
// Directed self-checking bench for div_8bit_seq; expectations follow DIV_SIGNED_EN.
module tb_div_8bit_seq;
  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_fail = 0;
  int   lat, bc;

  always #5 clk = ~clk;

  div_8bit_seq_if #(.WIDTH(8)) bus ();
  div_8bit_seq #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present start for one cycle; returns at the sample point right after the accepting edge
  task automatic start_op(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    bus.dividend = a;
    bus.divisor  = b;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // lat = edges after the accepting edge until done is seen; bc = samples with busy high
  task automatic wait_done(output int l, output int b);
    l = 0;
    b = 0;
    while (l < 40) begin
      if (bus.busy) b++;
      if (bus.done) break;
      @(negedge clk);
      l++;
    end
  endtask

  task automatic check_result(input string tag, input logic [7:0] q, input logic [7:0] r,
                              input logic dz, input logic ov);
    check({tag, " quotient"}, 32'(bus.quotient), 32'(q));
    check({tag, " remainder"}, 32'(bus.remainder), 32'(r));
    check({tag, " div_by_zero"}, 32'(bus.div_by_zero), 32'(dz));
    check({tag, " overflow"}, 32'(bus.overflow), 32'(ov));
  endtask

  task automatic check_reset(input string tag);
    check({tag, " ready"}, 32'(bus.ready), 32'd1);
    check({tag, " busy"}, 32'(bus.busy), 32'd0);
    check({tag, " done"}, 32'(bus.done), 32'd0);
    check_result(tag, 8'h00, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    repeat (2) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;

    // 200 / 7
    start_op(8'd200, 8'd7);
    check("200/7 busy after accept", 32'(bus.busy), 32'd1);
    check("200/7 ready after accept", 32'(bus.ready), 32'd0);
    wait_done(lat, bc);
    check("200/7 latency", 32'(lat), 32'd8);
    check("200/7 busy cycles", 32'(bc), 32'd8);
    check("200/7 ready at done", 32'(bus.ready), 32'd1);
    check_result("200/7", 8'd28, 8'd4, 1'b0, 1'b0);
    @(negedge clk);
    check("200/7 done pulse ends", 32'(bus.done), 32'd0);
    check("200/7 quotient held", 32'(bus.quotient), 32'd28);

    // 5 / 0
    start_op(8'd5, 8'd0);
    wait_done(lat, bc);
    check("5/0 latency", 32'(lat), 32'd0);
    check("5/0 busy cycles", 32'(bc), 32'd0);
    check_result("5/0", 8'hFF, 8'h05, 1'b1, 1'b0);

    // 3 / 9, then 255 / 1 accepted on the done cycle
    start_op(8'd3, 8'd9);
    wait_done(lat, bc);
    check("3/9 latency", 32'(lat), 32'd8);
    check_result("3/9", 8'd0, 8'd3, 1'b0, 1'b0);
    bus.dividend = 8'd255;
    bus.divisor  = 8'd1;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("255/1 back-to-back busy", 32'(bus.busy), 32'd1);
    wait_done(lat, bc);
    check("255/1 latency", 32'(lat), 32'd8);
    check_result("255/1", 8'd255, 8'd0, 1'b0, 1'b0);

    // Reset during step 4 of 100 / 3
    start_op(8'd100, 8'd3);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset("mid-op reset");
    rst = 1'b0;
    start_op(8'd100, 8'd3);
    wait_done(lat, bc);
    check("100/3 latency", 32'(lat), 32'd8);
    check_result("100/3", 8'd33, 8'd1, 1'b0, 1'b0);

    // rst and start together: rst wins
    @(negedge clk);
    rst = 1'b1;
    bus.dividend = 8'd9;
    bus.divisor  = 8'd3;
    bus.start    = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.start = 1'b0;
    check_reset("rst with start");

    // Boundaries
    start_op(8'd0, 8'd5);
    wait_done(lat, bc);
    check_result("0/5", 8'd0, 8'd0, 1'b0, 1'b0);
    start_op(8'd7, 8'd7);
    wait_done(lat, bc);
    check_result("7/7", 8'd1, 8'd0, 1'b0, 1'b0);

    // Sign-sensitive vectors
    start_op(8'h9C, 8'd7);
    wait_done(lat, bc);
    check("9C/07 latency", 32'(lat), 32'd8);
`ifdef DIV_SIGNED_EN
    check_result("9C/07", 8'hF2, 8'hFE, 1'b0, 1'b0);
`else
    check_result("9C/07", 8'h16, 8'h02, 1'b0, 1'b0);
`endif
    start_op(8'h80, 8'hFF);
    wait_done(lat, bc);
    check("80/FF latency", 32'(lat), 32'd8);
`ifdef DIV_SIGNED_EN
    check_result("80/FF", 8'h80, 8'h00, 1'b0, 1'b1);
`else
    check_result("80/FF", 8'h00, 8'h80, 1'b0, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
